// File: rtl/vga_cursor_gen.sv
// Text-mode cursor overlay: frame-shadowed cursor registers, hardware blink,
// and a fixed-latency hit pipeline aligned with the glyph fetch.
module vga_cursor_gen #(
  parameter int BLINK_FRAMES = 16,
  parameter int PIPE_DELAY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        cursor_enabled,
  input  logic [14:0] cursor_pos,
  input  logic [2:0]  cursor_scan_start,
  input  logic [2:0]  cursor_scan_end,
  input  logic        char_valid,
  input  logic [14:0] char_addr,
  input  logic [2:0]  scanline,
  output logic        cursor_active,
  output logic        blink_phase
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_FRAME = CW'(BLINK_FRAMES - 1);

  logic                  shadow_enabled;
  logic [14:0]           shadow_pos;
  logic [2:0]            shadow_start;
  logic [2:0]            shadow_end;
  logic [CW-1:0]         frame_cnt;
  logic                  blink_q;
  logic                  hit;
  logic [PIPE_DELAY-1:0] pipe;

  // Shadows only move at frame_start so a CPU write can never tear a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_enabled <= 1'b0;
      shadow_pos     <= '0;
      shadow_start   <= '0;
      shadow_end     <= '0;
      frame_cnt      <= '0;
      blink_q        <= 1'b1;
    end else if (frame_start) begin
      shadow_enabled <= cursor_enabled;
      shadow_pos     <= cursor_pos;
      shadow_start   <= cursor_scan_start;
      shadow_end     <= cursor_scan_end;
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
      end
    end
  end

  // Inverted scan ranges simply never match; there is no split cursor.
  always_comb begin
    hit = char_valid & shadow_enabled & blink_q &
          (char_addr == shadow_pos) &
          (shadow_start <= scanline) & (scanline <= shadow_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= hit;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign cursor_active = pipe[PIPE_DELAY-1];
  assign blink_phase   = blink_q;

endmodule

// File: tb/tb_vga_cursor_gen.sv
// Randomized + directed bench for vga_cursor_gen: three parameterisations share
// one stimulus stream and are checked each cycle against a frame-count model.
module tb_vga_cursor_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        cursor_enabled = 1'b0;
  logic [14:0] cursor_pos = '0;
  logic [2:0]  cursor_scan_start = '0;
  logic [2:0]  cursor_scan_end = '0;
  logic        char_valid = 1'b0;
  logic [14:0] char_addr = '0;
  logic [2:0]  scanline = '0;
  logic [2:0]  act;
  logic [2:0]  blk;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_cursor_gen #(.BLINK_FRAMES(4), .PIPE_DELAY(2)) dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .cursor_enabled(cursor_enabled), .cursor_pos(cursor_pos),
    .cursor_scan_start(cursor_scan_start), .cursor_scan_end(cursor_scan_end),
    .char_valid(char_valid), .char_addr(char_addr), .scanline(scanline),
    .cursor_active(act[0]), .blink_phase(blk[0]));

  vga_cursor_gen #(.BLINK_FRAMES(2), .PIPE_DELAY(1)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .cursor_enabled(cursor_enabled), .cursor_pos(cursor_pos),
    .cursor_scan_start(cursor_scan_start), .cursor_scan_end(cursor_scan_end),
    .char_valid(char_valid), .char_addr(char_addr), .scanline(scanline),
    .cursor_active(act[1]), .blink_phase(blk[1]));

  vga_cursor_gen #(.BLINK_FRAMES(1), .PIPE_DELAY(3)) dut_c (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .cursor_enabled(cursor_enabled), .cursor_pos(cursor_pos),
    .cursor_scan_start(cursor_scan_start), .cursor_scan_end(cursor_scan_end),
    .char_valid(char_valid), .char_addr(char_addr), .scanline(scanline),
    .cursor_active(act[2]), .blink_phase(blk[2]));

  function automatic int bf_of(int i);
    case (i)
      0: return 4;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int pd_of(int i);
    case (i)
      0: return 2;
      1: return 1;
      default: return 3;
    endcase
  endfunction

  // Model: blink is a pure function of frames seen since reset; hits are a history line.
  bit m_valid = 1'b0;
  bit m_en;
  int m_pos, m_st, m_end;
  int nframes;
  bit hist [3][4];

  function automatic bit model_phase(int i);
    return ((nframes / bf_of(i)) % 2) == 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1;
      m_en = 1'b0; m_pos = 0; m_st = 0; m_end = 0;
      nframes = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 4; j++) hist[i][j] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = char_valid && m_en && model_phase(i) &&
                     (int'(char_addr) == m_pos) &&
                     (m_st <= int'(scanline)) && (int'(scanline) <= m_end);
      end
      if (frame_start) begin
        m_en  = cursor_enabled;
        m_pos = int'(cursor_pos);
        m_st  = int'(cursor_scan_start);
        m_end = int'(cursor_scan_end);
        nframes++;
      end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0b expected %0b", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model cursor_active[%0d]", i), act[i], hist[i][pd_of(i)-1]);
        checkOutput($sformatf("model blink_phase[%0d]", i), blk[i], model_phase(i));
      end
    end
  end

  // Drives one cycle of inputs, returns just after the edge that consumed them.
  task automatic applyStimulus(input logic rst, input logic fs, input logic cv,
                               input logic [14:0] addr, input logic [2:0] sl);
    reset = rst; frame_start = fs; char_valid = cv; char_addr = addr; scanline = sl;
    @(posedge clk);
    #1;
  endtask

  task automatic setCursor(input logic en, input logic [14:0] pos,
                           input logic [2:0] st, input logic [2:0] en_sl);
    cursor_enabled = en; cursor_pos = pos;
    cursor_scan_start = st; cursor_scan_end = en_sl;
  endtask

  logic ra [10];
  logic rb [10];
  int   pat [12] = '{1,1,1,0,0,0,0,1,1,1,1,0};
  logic [14:0] pick;

  initial begin
    // Basic hit window at 0x00A5, scanlines 6..7
    setCursor(1'b1, 15'h00A5, 3'd6, 3'd7);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset cursor_active", act[0], 1'b0);
    checkOutput("reset blink_phase", blk[0], 1'b1);
    applyStimulus(0, 1, 0, 0, 0);
    for (int s = 0; s < 10; s++) begin
      if (s < 8) applyStimulus(0, 0, 1, 15'h00A5, 3'(s));
      else       applyStimulus(0, 0, 0, 0, 0);
      ra[s] = act[0];
      rb[s] = act[1];
    end
    for (int s = 0; s < 10; s++) begin
      checkOutput($sformatf("window A step %0d", s), ra[s], (s == 7 || s == 8));
      checkOutput($sformatf("window B step %0d", s), rb[s], (s == 6 || s == 7));
    end
    applyStimulus(0, 0, 1, 15'h00A4, 3'd6);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("neighbour cell", act[0], 1'b0);

    // Live pos change must wait for frame_start
    cursor_pos = 15'h0010;
    applyStimulus(0, 0, 1, 15'h00A5, 3'd6);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("old pos still hits", act[0], 1'b1);
    applyStimulus(0, 0, 1, 15'h0010, 3'd6);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("new pos before frame", act[0], 1'b0);
    applyStimulus(0, 1, 1, 15'h0010, 3'd6);
    applyStimulus(0, 0, 1, 15'h0010, 3'd6);
    checkOutput("coincident frame_start", act[0], 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("new pos after frame", act[0], 1'b1);

    // Blink pattern for BLINK_FRAMES=4
    setCursor(1'b1, 15'h00A5, 3'd6, 3'd7);
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput($sformatf("blink pulse %0d", k + 1), blk[0], pat[k] == 1);
    end
    applyStimulus(0, 0, 1, 15'h00A5, 3'd6);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("hidden blink phase", act[0], 1'b0);

    // Inverted range, then disabled cursor
    setCursor(1'b1, 15'h00A5, 3'd5, 3'd2);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    for (int s = 0; s < 10; s++) begin
      if (s < 8) applyStimulus(0, 0, 1, 15'h00A5, 3'(s));
      else       applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("inverted range %0d", s), act[0], 1'b0);
    end
    setCursor(1'b0, 15'h00A5, 3'd0, 3'd7);
    applyStimulus(0, 1, 0, 0, 0);
    for (int s = 0; s < 10; s++) begin
      if (s < 8) applyStimulus(0, 0, 1, 15'h00A5, 3'(s));
      else       applyStimulus(0, 0, 0, 0, 0);
      checkOutput($sformatf("disabled %0d", s), act[0], 1'b0);
    end

    // Reset while a hit sits in stage 1
    setCursor(1'b1, 15'h00A5, 3'd0, 3'd7);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 15'h00A5, 3'd3);
    applyStimulus(1, 0, 1, 15'h00A5, 3'd3);
    checkOutput("reset flushes pipe", act[0], 1'b0);
    checkOutput("reset blink", blk[0], 1'b1);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 0, 1, 15'h0000, 3'd0);
      checkOutput($sformatf("cleared shadow %0d", s), act[0], 1'b0);
    end

    // PIPE_DELAY=1 hit/miss/hit
    setCursor(1'b1, 15'h0000, 3'd0, 3'd7);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 15'h0000, 3'd2);
    checkOutput("pd1 hit", act[1], 1'b1);
    applyStimulus(0, 0, 1, 15'h0005, 3'd2);
    checkOutput("pd1 miss", act[1], 1'b0);
    applyStimulus(0, 0, 1, 15'h0000, 3'd2);
    checkOutput("pd1 hit again", act[1], 1'b1);

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: pick = 15'h00A5;
          1: pick = 15'h0010;
          2: pick = 15'(2000 + $urandom_range(0, 40));
          default: pick = 15'($urandom);
        endcase
        setCursor($urandom_range(0, 3) != 0, pick,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
      case ($urandom_range(0, 3))
        0: pick = 15'h00A5;
        1: pick = 15'h0010;
        2: pick = cursor_pos;
        default: pick = 15'($urandom_range(0, 1999));
      endcase
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0, pick, 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
